ov7670_stream_gen: RTL and testbench

//  Synthetic OV7670 camera: drives PCLK/VSYNC/HREF/D[7:0] with frame timing the

---
 rtl/ov7670_stream_gen_if.sv | 10 +
 rtl/ov7670_stream_gen.sv | 146 ++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_stream_gen_if.sv
// Camera-side pin bundle of the synthetic OV7670: pixel clock, syncs and data byte.
interface ov7670_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output pclk, vsync, href, data);
    modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 sensor: free-running pclk = clk/2, frame/line timing and
// deterministic test patterns. All camera outputs move only on the clk edge
// where pclk falls (one "tick" per pclk period), so they are stable at pclk rise.
module ov7670_stream_gen #(
    parameter int H_ACTIVE      = 320,
    parameter int V_ACTIVE      = 240,
    parameter int VSYNC_PCLKS   = 64,
    parameter int V_BACK_PCLKS  = 128,
    parameter int H_BLANK_PCLKS = 144,
    parameter int V_FRONT_PCLKS = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    ov7670_stream_gen_if.master        cam,
    output logic                       frame_start,
    output logic                       busy,
    output logic [7:0]                 frame_cnt
);
    typedef enum logic [2:0] {IDLE, VSYNC, V_BACK, LINE, H_BLANK, V_FRONT} state_t;

    // Terminal counts: a state with length N ends on the tick where cnt == N-1.
    localparam logic [15:0] VS_LAST = 16'(VSYNC_PCLKS - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BACK_PCLKS - 1);
    localparam logic [15:0] LN_LAST = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK_PCLKS - 1);
    localparam logic [15:0] VF_LAST = 16'(V_FRONT_PCLKS - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  mode_q;
    logic        pclk_q, tick, start_d;
    logic        vsync_q, href_q;
    logic [7:0]  data_q, data_d;
    logic [15:0] pix;

    // pclk is about to fall on this edge -> this is an update tick
    assign tick = pclk_q;

    function automatic logic [15:0] pixel(input logic [9:0] x, input logic [9:0] y,
                                          input logic [1:0] m, input logic [7:0] f);
        case (m)
            2'd0:    return {x[7:0], x[7:0]};
            2'd1:    return {y[7:0], y[7:0]};
            2'd2:    return (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: return {f, f};
        endcase
    endfunction

    // Next state: cnt counts ticks spent in the current state (bytes while in LINE)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        y_d     = y_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = VSYNC;
                    start_d = 1'b1;
                    y_d     = '0;
                end
            end
            VSYNC:   if (cnt_q == VS_LAST) begin state_d = V_BACK; cnt_d = '0; end
            V_BACK:  if (cnt_q == VB_LAST) begin state_d = LINE;   cnt_d = '0; end
            LINE: if (cnt_q == LN_LAST) begin
                cnt_d   = '0;
                // last line skips the horizontal blank and goes straight to the front porch
                state_d = (y_q == Y_LAST) ? V_FRONT : H_BLANK;
            end
            H_BLANK: if (cnt_q == HB_LAST) begin
                cnt_d   = '0;
                state_d = LINE;
                y_d     = y_q + 10'd1;
            end
            V_FRONT: if (cnt_q == VF_LAST) begin
                cnt_d = '0;
                if (enable) begin
                    state_d = VSYNC;
                    start_d = 1'b1;
                    y_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin state_d = IDLE; cnt_d = '0; end
        endcase
    end

    // Byte for the position being entered; mode_q/frame_cnt were fixed at VSYNC rise
    always_comb begin
        pix    = pixel(cnt_d[10:1], y_d, mode_q, frame_cnt);
        data_d = 8'h00;
        if (state_d == LINE) data_d = cnt_d[0] ? pix[7:0] : pix[15:8];
    end

    // FSM state register, advanced once per pclk period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
        end else if (tick) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    // pclk divider, registered camera outputs and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'h00;
            mode_q      <= 2'd0;
        end else begin
            pclk_q      <= ~pclk_q;
            frame_start <= 1'b0;
            if (tick) begin
                vsync_q     <= (state_d == VSYNC);
                href_q      <= (state_d == LINE);
                data_q      <= data_d;
                busy        <= (state_d != IDLE);
                frame_start <= start_d;
                if (start_d) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    mode_q    <= mode;
                end
            end
        end
    end

    assign cam.pclk  = pclk_q;
    assign cam.vsync = vsync_q;
    assign cam.href  = href_q;
    assign cam.data  = data_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen: expected bytes are queued per frame
// when a run is launched and popped on every href-high pclk period.
module tb_ov7670_stream_gen;
    localparam int H = 16, V = 16, VS = 2, VB = 3, HB = 2, VF = 3;
    localparam int FT = VS + VB + V * 2 * H + (V - 1) * HB + VF;

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       frame_start, busy;
    logic [7:0] frame_cnt;

    ov7670_stream_gen_if cam();

    ov7670_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_PCLKS(VS), .V_BACK_PCLKS(VB),
        .H_BLANK_PCLKS(HB), .V_FRONT_PCLKS(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .cam(cam),
        .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_run = 0, n_fail = 0;
    logic [7:0]  sb[$];
    int          busy_ticks, href_ticks, vs_rises, fs_clks;
    logic        prev_vs, have_snap;
    logic [18:0] snap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int x, input int y, input logic [1:0] m,
                                              input logic [7:0] f);
        logic [9:0] xv, yv;
        xv = 10'(x);
        yv = 10'(y);
        case (m)
            2'd0:    return {xv[7:0], xv[7:0]};
            2'd1:    return {yv[7:0], yv[7:0]};
            2'd2:    return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
            default: return {f, f};
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [7:0] f);
        logic [15:0] p;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                p = model_pix(x, y, m, f);
                sb.push_back(p[15:8]);
                sb.push_back(p[7:0]);
            end
    endtask

    // Monitor: snapshot after each pclk fall, sample again mid-high; nothing may move in between
    always @(negedge clk) begin
        if (!rst_n) begin
            have_snap = 1'b0;
            prev_vs   = 1'b0;
        end else begin
            if (frame_start) fs_clks++;
            if (cam.pclk) begin
                if (have_snap)
                    chk("stable", 32'({cam.vsync, cam.href, busy, cam.data, frame_cnt}), 32'(snap));
                if (busy) busy_ticks++;
                if (cam.vsync && !prev_vs) vs_rises++;
                prev_vs = cam.vsync;
                if (cam.href) begin
                    href_ticks++;
                    chk("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) chk("data", 32'(cam.data), 32'(sb.pop_front()));
                end else begin
                    chk("blank_data", 32'(cam.data), 0);
                end
            end else begin
                snap      = {cam.vsync, cam.href, busy, cam.data, frame_cnt};
                have_snap = 1'b1;
            end
        end
    end

    task automatic clr();
        busy_ticks = 0; href_ticks = 0; vs_rises = 0; fs_clks = 0;
    endtask

    // Reset, queue nfr frames (first in mode m, rest in m2), release and check first VSYNC tick
    task automatic start(input string tag, input logic [1:0] m, input logic [1:0] m2, input int nfr);
        int n;
        rst_n = 1'b0;
        enable = 1'b1;
        mode = m;
        sb.delete();
        #12;
        clr();
        for (int i = 0; i < nfr; i++) push_frame(i == 0 ? m : m2, 8'(i + 1));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!cam.vsync && n < 20);
        chk({tag, "_vs_first_tick"}, n, 2);
        chk({tag, "_fs_pulse"}, frame_start, 1);
        chk({tag, "_busy_rise"}, busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 8 * 2 * FT) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic wait_href();
        int n = 0;
        while (!cam.href && n < 4 * FT) begin @(negedge clk); n++; end
        chk("href_seen", cam.href, 1);
    endtask

    task automatic wait_fs(input int k);
        int n = 0;
        while (fs_clks < k && n < 8 * FT) begin @(negedge clk); n++; end
        chk("fs_wait", fs_clks, k);
    endtask

    task automatic end_checks(input string tag, input int frames);
        chk({tag, "_busy_ticks"}, busy_ticks, frames * FT);
        chk({tag, "_href_ticks"}, href_ticks, frames * V * 2 * H);
        chk({tag, "_vs_rises"}, vs_rises, frames);
        chk({tag, "_fs_clks"}, fs_clks, frames);
        chk({tag, "_frame_cnt"}, frame_cnt, frames);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_pclk", cam.pclk, 0);
        chk("rst_vsync", cam.vsync, 0);
        chk("rst_href", cam.href, 0);
        chk("rst_data", cam.data, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // horizontal ramp, single frame
        start("t1", 2'd0, 2'd0, 1);
        enable = 1'b0;
        wait_done("t1");
        end_checks("t1", 1);

        // checkerboard
        start("t2", 2'd2, 2'd2, 1);
        enable = 1'b0;
        wait_done("t2");
        end_checks("t2", 1);

        // frame counter pattern over three back-to-back frames
        start("t3", 2'd3, 2'd3, 3);
        wait_fs(3);
        enable = 1'b0;
        wait_done("t3");
        end_checks("t3", 3);

        // enable dropped mid-line: frame completes, then stays idle
        start("t4", 2'd1, 2'd1, 1);
        wait_href();
        enable = 1'b0;
        wait_done("t4");
        repeat (4 * FT) @(negedge clk);
        end_checks("t4", 1);

        // async reset mid-line, then restart from VSYNC
        start("t5", 2'd0, 2'd0, 1);
        wait_href();
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_pclk", cam.pclk, 0);
        chk("t5_vsync", cam.vsync, 0);
        chk("t5_href", cam.href, 0);
        chk("t5_data", cam.data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_fcnt", frame_cnt, 0);
        start("t5r", 2'd0, 2'd0, 1);
        enable = 1'b0;
        wait_done("t5r");
        end_checks("t5r", 1);

        // mode change mid-frame only takes effect at the next VSYNC rise
        start("t6", 2'd0, 2'd2, 2);
        wait_href();
        mode = 2'd2;
        wait_fs(2);
        enable = 1'b0;
        wait_done("t6");
        end_checks("t6", 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
